key_event_tracker: RTL and testbench
====================================

Name: key_event_tracker

Overview:
- Sits directly downstream of the matrix keyboard scanner and replaces the raw per-key state decode.
- Consumes the scanner's debounced key_code/key_vaild pair.
- Produces per-key one-cycle event pulses (press, release, long-press, auto-repeat) and per-key level outputs (held, toggle).
- The clock UI and mode logic consume these outputs, so up/down buttons auto-repeat and mode/adjust can distinguish short and long presses.

Parameters:
- LONG_CYCLES, 100_000_000: cycles a key must stay held before key_long fires (1 s at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 20_000_000: cycles between successive key_repeat pulses after key_long; must be >= 1.
- CNT_W, 32: width of the hold counter; must hold LONG_CYCLES and REPEAT_CYCLES.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- key_code, input, 4: index 0-15 of the debounced key; only meaningful while key_vaild=1.
- key_vaild, input, 1: level, high for as long as a debounced key is held.
- key_press, output, 16: one-cycle pulse on bit[code] when the press is accepted.
- key_release, output, 16: one-cycle pulse on bit[code] when the press ends.
- key_long, output, 16: one-cycle pulse on bit[code] after LONG_CYCLES of continuous hold.
- key_repeat, output, 16: one-cycle pulse on bit[code] every REPEAT_CYCLES after key_long.
- key_held, output, 16: level; bit[code]=1 from the cycle of key_press through the cycle of key_release, exclusive.
- key_toggle, output, 16: bit[code] inverts on every accepted press.
- cur_code, output, 4: code of the key currently tracked; holds the last value after release.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, registered code 0. Reset asserted mid-hold aborts the hold with no release pulse and clears key_toggle.
- All outputs are registered. Latency is one cycle from an input change to its pulse.
- Single-key tracking: at most one bit of key_held is 1 at any time.
- State IDLE:
  - key_vaild=1 in cycle N: latch code C, cnt<=0, go to HELD.
  - Cycle N+1: key_press[C]=1, key_held[C]=1, key_toggle[C] inverted, cur_code=C.
- State HELD:
  - cnt increments each cycle while key_vaild=1 and key_code==C.
  - When cnt reaches LONG_CYCLES-1: next cycle key_long[C]=1, cnt<=0, go to LONGH.
  - With the default, key_long appears LONG_CYCLES cycles after key_press.
- State LONGH:
  - cnt increments; when cnt reaches REPEAT_CYCLES-1, next cycle key_repeat[C]=1 and cnt<=0.
  - The repeat is periodic with period REPEAT_CYCLES.
  - The first key_repeat occurs REPEAT_CYCLES cycles after key_long.
- Release (HELD or LONGH, key_vaild=0): next cycle key_release[C]=1, key_held[C]=0, go to IDLE. A same-cycle long/repeat terminal count is suppressed; release wins.
- Code change while held (key_vaild=1, key_code!=C):
  - Treated as a release of C followed by a press of the new code.
  - Cycle +1: key_release[C]=1, go to IDLE with the new code pending.
  - Cycle +2: key_press[new]=1.
  - key_held is 0 for exactly one cycle between them.
- IDLE with key_vaild=1 immediately after a release is a fresh press; there is no lockout.
- Pulse exclusivity: key_press, key_long, key_repeat and key_release never overlap in the same cycle for the same key.
- Counter: unsigned CNT_W bits, never wraps. It is cleared on each state entry and saturates conceptually at the terminal count.
- key_vaild glitches shorter than one cycle are not filtered here; debouncing is the scanner's responsibility.

Test Plan:
- Reset, then key_vaild=0 for 50 cycles -> all 16-bit outputs stay 0x0000, cur_code=0.
- LONG_CYCLES=8, REPEAT_CYCLES=3; press code 5 for 4 cycles, then release:
  - key_press=0x0020 once, key_held=0x0020 for 4 cycles.
  - key_release=0x0020 once; no key_long; key_toggle=0x0020.
- Same parameters, hold code 2 for 20 cycles:
  - key_press at t+1, key_long=0x0004 at t+9.
  - key_repeat=0x0004 at t+12, t+15, t+18.
  - key_release at t+21.
- Hold code 3, switch to code 9 without dropping key_vaild:
  - key_release=0x0008 at the next cycle, key_press=0x0200 one cycle later.
  - key_held=0 for 1 cycle between; cur_code=9.
- Press code 3 twice, with short releases -> key_toggle bit3 goes 1, then 0; two key_press pulses, two key_release pulses.
- Assert reset while code 7 is held in LONGH -> next cycle all outputs 0, no key_release. After reset deasserts with key_vaild=1, a fresh key_press=0x0080 follows one cycle later.

Source files
------------

// File: rtl/key_event_tracker.sv
`default_nettype none
// ============================================================================
// Module      : key_event_tracker
// Description : Turns the scanner's debounced key_code/key_vaild pair into
//               per-key event pulses (press, release, long-press, auto-repeat)
//               and per-key levels (held, toggle). Only one key is tracked at
//               a time; a code change while held is a release then a press.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   key_code_i     [3:0]  debounced key index, valid while key_vaild_i=1
//   key_vaild_i    level, high while a debounced key is held
//   key_press_o    [15:0] one-cycle pulse when a press is accepted
//   key_release_o  [15:0] one-cycle pulse when the press ends
//   key_long_o     [15:0] one-cycle pulse after LONG_CYCLES of hold
//   key_repeat_o   [15:0] one-cycle pulse every REPEAT_CYCLES after long
//   key_held_o     [15:0] level, bit set while the key is tracked as held
//   key_toggle_o   [15:0] bit inverts on every accepted press
//   cur_code_o     [3:0]  code of the tracked key, kept after release
// ============================================================================
module key_event_tracker #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int CNT_W         = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_code_i,
    input  logic        key_vaild_i,
    output logic [15:0] key_press_o,
    output logic [15:0] key_release_o,
    output logic [15:0] key_long_o,
    output logic [15:0] key_repeat_o,
    output logic [15:0] key_held_o,
    output logic [15:0] key_toggle_o,
    output logic [3:0]  cur_code_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HELD  = 2'd1,
        S_LONGH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic [15:0]        press_q, press_d;
    logic [15:0]        release_q, release_d;
    logic [15:0]        long_q, long_d;
    logic [15:0]        repeat_q, repeat_d;
    logic [15:0]        held_q, held_d;
    logic [15:0]        toggle_q, toggle_d;

    logic [15:0]        w_new_bit;
    logic [15:0]        w_cur_bit;
    logic               w_still_held;

    assign w_new_bit    = 16'(1) << key_code_i;
    assign w_cur_bit    = 16'(1) << code_q;
    // A different code while valid counts as the tracked key going away.
    assign w_still_held = key_vaild_i && (key_code_i == code_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        held_d    = held_q;
        toggle_d  = toggle_q;

        case (state_q)
            S_IDLE: begin
                if (key_vaild_i) begin
                    code_d   = key_code_i;
                    cnt_d    = '0;
                    state_d  = S_HELD;
                    press_d  = w_new_bit;
                    held_d   = w_new_bit;
                    toggle_d = toggle_q ^ w_new_bit;
                end
            end

            S_HELD, S_LONGH: begin
                if (!w_still_held) begin
                    // Release takes priority over a coinciding terminal count.
                    release_d = w_cur_bit;
                    held_d    = '0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else if (state_q == S_HELD) begin
                    if (cnt_q == c_LONG_TC) begin
                        long_d  = w_cur_bit;
                        cnt_d   = '0;
                        state_d = S_LONGH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == c_REPEAT_TC) begin
                        repeat_d = w_cur_bit;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                held_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            held_q    <= '0;
            toggle_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_long_o    = long_q;
    assign key_repeat_o  = repeat_q;
    assign key_held_o    = held_q;
    assign key_toggle_o  = toggle_q;
    assign cur_code_o    = code_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_tracker
// Description : Self-checking bench for key_event_tracker with a reference
//               model based on hold age (cycles since press) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_tracker;

    localparam int LONG   = 8;
    localparam int REPEAT = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_vaild;
    logic [15:0] key_press, key_release, key_long, key_repeat, key_held, key_toggle;
    logic [3:0]  cur_code;

    key_event_tracker #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .key_code_i    (key_code),
        .key_vaild_i   (key_vaild),
        .key_press_o   (key_press),
        .key_release_o (key_release),
        .key_long_o    (key_long),
        .key_repeat_o  (key_repeat),
        .key_held_o    (key_held),
        .key_toggle_o  (key_toggle),
        .cur_code_o    (cur_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [15:0] m_press, m_release, m_long, m_repeat, m_held, m_toggle;
    logic [3:0]  m_cur;
    bit          m_active;
    int          m_age;

    logic [99:0] dut_all;
    logic [99:0] exp_all;
    assign dut_all = {key_press, key_release, key_long, key_repeat, key_held, key_toggle, cur_code};
    assign exp_all = {m_press, m_release, m_long, m_repeat, m_held, m_toggle, m_cur};

    // Apply one cycle of input, advance the model, land 1 time unit after the edge.
    task automatic step(input bit r, input bit v, input logic [3:0] c);
        logic [15:0] cbit;
        rst       = r;
        key_vaild = v;
        key_code  = c;
        @(posedge clk);
        m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
        if (r) begin
            m_active = 0; m_cur = '0; m_toggle = '0; m_age = 0;
        end else if (!m_active) begin
            if (v) begin
                cbit     = 16'd1 << c;
                m_active = 1; m_cur = c; m_age = 0;
                m_press  = cbit;
                m_toggle = m_toggle ^ cbit;
            end
        end else if (!v || c != m_cur) begin
            m_release = 16'd1 << m_cur;
            m_active  = 0;
        end else begin
            m_age++;
            if (m_age == LONG)
                m_long = 16'd1 << m_cur;
            else if (m_age > LONG && ((m_age - LONG) % REPEAT) == 0)
                m_repeat = 16'd1 << m_cur;
        end
        m_held = m_active ? (16'd1 << m_cur) : 16'd0;
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        vectors++;
        if (dut_all !== 100'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", dut_all, 100'd0);
        end
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 4'($urandom_range(0, 15)));
            vectors++;
            if (dut_all !== exp_all || dut_all !== 100'd0) begin
                errors++;
                $display("FAIL idle_quiet cyc %0d: got %h required %h", i, dut_all, exp_all);
            end
        end
    endtask

    task automatic test_short_press();
        int presses = 0, releases = 0, held_cyc = 0, longs = 0;
        for (int k = 0; k < 7; k++) begin
            step(0, (k < 4), 4'd5);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL short_press k=%0d: got %h required %h", k, dut_all, exp_all);
            end
            if (key_press == 16'h0020) presses++;
            if (key_release == 16'h0020) releases++;
            if (key_held == 16'h0020) held_cyc++;
            if (key_long != 0) longs++;
        end
        vectors++;
        if (presses != 1 || releases != 1 || held_cyc != 4 || longs != 0 || key_toggle !== 16'h0020) begin
            errors++;
            $display("FAIL short_press_summary: got p=%0d r=%0d h=%0d l=%0d t=%h required 1 1 4 0 0020",
                     presses, releases, held_cyc, longs, key_toggle);
        end
    endtask

    task automatic test_long_repeat();
        int long_at = -1, press_at = -1, rel_at = -1;
        int rep_at[$];
        for (int k = 0; k < 24; k++) begin
            step(0, (k < 20), 4'd2);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL long_repeat k=%0d: got %h required %h", k, dut_all, exp_all);
            end
            if (key_press == 16'h0004) press_at = k + 1;
            if (key_long == 16'h0004) long_at = k + 1;
            if (key_repeat == 16'h0004) rep_at.push_back(k + 1);
            if (key_release == 16'h0004) rel_at = k + 1;
        end
        vectors++;
        if (press_at != 1 || long_at != 9 || rel_at != 21) begin
            errors++;
            $display("FAIL long_timing: got press=%0d long=%0d rel=%0d required 1 9 21",
                     press_at, long_at, rel_at);
        end
        vectors++;
        if (rep_at.size() != 3 || rep_at[0] != 12 || rep_at[1] != 15 || rep_at[2] != 18) begin
            errors++;
            $display("FAIL repeat_timing: got %p required '{12,15,18}", rep_at);
        end
    endtask

    task automatic test_code_change();
        int gap = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, (k < 7), (k < 3) ? 4'd3 : 4'd9);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL code_change k=%0d: got %h required %h", k, dut_all, exp_all);
            end
            // k=3 is the first cycle with code 9 on the input
            if (k == 3 && key_release !== 16'h0008) begin
                errors++;
                $display("FAIL change_release: got %h required 0008", key_release);
            end
            if (k == 4 && (key_press !== 16'h0200 || cur_code !== 4'd9)) begin
                errors++;
                $display("FAIL change_press: got %h/%0d required 0200/9", key_press, cur_code);
            end
            if (k >= 1 && k <= 5 && key_held == 0) gap++;
        end
        vectors++;
        if (gap != 1) begin
            errors++;
            $display("FAIL change_gap: got %0d required 1", gap);
        end
    endtask

    task automatic test_toggle_twice();
        logic [1:0] tog_seen = '0;
        int presses = 0, releases = 0;
        step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, (k == 0 || k == 1 || k == 4 || k == 5), 4'd3);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL toggle k=%0d: got %h required %h", k, dut_all, exp_all);
            end
            if (key_press == 16'h0008) begin
                presses++;
                tog_seen = {tog_seen[0], key_toggle[3]};
            end
            if (key_release == 16'h0008) releases++;
        end
        vectors++;
        if (presses != 2 || releases != 2 || tog_seen !== 2'b10) begin
            errors++;
            $display("FAIL toggle_summary: got p=%0d r=%0d seq=%b required 2 2 10", presses, releases, tog_seen);
        end
    endtask

    task automatic test_reset_mid_hold();
        for (int k = 0; k < LONG + 3; k++) begin
            step(0, 1, 4'd7);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL mid_hold k=%0d: got %h required %h", k, dut_all, exp_all);
            end
        end
        step(1, 1, 4'd7);
        vectors++;
        if (dut_all !== 100'd0) begin
            errors++;
            $display("FAIL reset_abort: got %h required %h", dut_all, 100'd0);
        end
        step(0, 1, 4'd7);
        vectors++;
        if (key_press !== 16'h0080 || dut_all !== exp_all) begin
            errors++;
            $display("FAIL fresh_press: got %h required %h", dut_all, exp_all);
        end
        step(0, 0, 4'd7);
    endtask

    task automatic test_random();
        bit         v = 0;
        logic [3:0] c = 0;
        bit         r;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 12) v = ~v;
            if ($urandom_range(0, 99) < 4) c = 4'($urandom_range(0, 15));
            step(r, v, c);
            vectors++;
            if (dut_all !== exp_all) begin
                errors++;
                $display("FAIL random cyc %0d: got %h required %h", i, dut_all, exp_all);
            end
        end
    endtask

    initial begin
        rst = 1; key_vaild = 0; key_code = 0;
        m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
        m_held = '0; m_toggle = '0; m_cur = '0; m_active = 0; m_age = 0;
        #1;
        test_reset();
        test_short_press();
        test_long_repeat();
        test_code_change();
        test_toggle_twice();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
